dbus_scratchpad: RTL

Data-bus responder: a tightly-coupled scratchpad SRAM that answers load/store-unit requests on the `data_memreq_t` / `data_memres_t` bus. It mimics the D-cache timing contract: a request/ready handshake, a fixed non-stalled response pipeline, and a `stall` back-pressure signal. It also provides a programmable wait-state window for uncached (MMIO-style) accesses. It sits on the dbus in place of, or beside, the D-cache for bring-up, simulation and on-chip scratch memory.

---
 rtl/dbus_scratchpad_if.sv | 40 ++++
 rtl/dbus_scratchpad.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dbus_scratchpad_if.sv
// Data-bus request/response bundle between a load/store unit (master) and a memory
// responder (slave): request/ready handshake plus a registered response with stall.
interface dbus_scratchpad_if;

    typedef struct packed {
        logic        read;
        logic        write;
        logic        uncached;
        logic        invalidate;
        logic [31:0] paddr;
        logic [31:0] wrdata;
        logic [3:0]  byteenable;
    } data_memreq_t;

    typedef struct packed {
        logic        stall;
        logic        last;
        logic [31:0] rddata;
    } data_memres_t;

    data_memreq_t req;
    logic         request;
    logic         ready;
    data_memres_t res;

    modport master (
        output req,
        output request,
        input  ready,
        input  res
    );

    modport slave (
        input  req,
        input  request,
        output ready,
        output res
    );

endinterface

// File: rtl/dbus_scratchpad.sv
// Scratchpad SRAM on the data bus: D-cache style fixed-latency response pipeline with an
// optional wait-state window that back-pressures the initiator after uncached accesses.
`ifndef DCACHE_PIPE_DEPTH
`define DCACHE_PIPE_DEPTH 3
`endif

module dbus_scratchpad #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned PIPE_DEPTH    = `DCACHE_PIPE_DEPTH,
    parameter int unsigned UNCACHED_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    dbus_scratchpad_if.slave  dbus
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam int unsigned NumStages = PIPE_DEPTH - 1;
    localparam int unsigned WaitW     = (UNCACHED_WAIT > 0) ? $clog2(UNCACHED_WAIT + 1) : 1;
    localparam logic [31:0] AddrMask  = ~(32'(4 * DEPTH_WORDS) - 32'd1);
    localparam logic [WaitW-1:0] WaitInit = WaitW'(UNCACHED_WAIT);
    localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;

    logic              ready;
    logic              accept;
    logic              stall;
    logic              in_range;
    logic              do_write;
    logic [IdxW-1:0]   idx;
    logic [31:0]       rd_word;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              pipe_valid_q [NumStages];
    logic [31:0]       pipe_data_q  [NumStages];

    // Decode
    assign in_range = (dbus.req.paddr & AddrMask) == BASE_ADDR;
    assign idx      = IdxW'((dbus.req.paddr - BASE_ADDR) >> 2);

    assign ready    = ~rst & (state_q == StIdle);
    assign accept   = dbus.request & ready;
    assign stall    = (state_q == StWait);
    assign do_write = accept & dbus.req.write & in_range & ~dbus.req.invalidate;

    // Read is sampled before this cycle's write lands, so a read+write returns the old word.
    assign rd_word  = (dbus.req.read && in_range && !dbus.req.invalidate) ? mem[idx] : 32'h0;

    assign dbus.ready = ready;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (dbus.req.byteenable[i]) begin
                    mem[idx][8*i +: 8] <= dbus.req.wrdata[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: a new entry enters every unstalled cycle (bubble if nothing accepted).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumStages; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_data_q[i]  <= 32'h0;
            end
        end else if (!stall) begin
            pipe_valid_q[0] <= accept;
            pipe_data_q[0]  <= rd_word;
            for (int i = 1; i < NumStages; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    // Wait-state window
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept && dbus.req.uncached && (UNCACHED_WAIT != 0)) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitInit;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q - WaitOne;
                if (wait_cnt_q == WaitOne) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, including its first cycle.
    always_comb begin
        dbus.res        = '0;
        dbus.res.stall  = stall & ~rst;
        dbus.res.rddata = (pipe_valid_q[NumStages-1] && !rst) ? pipe_data_q[NumStages-1] : 32'h0;
    end

endmodule
